// File: rtl/hidden_vector_serializer.sv
// Hidden-layer vector serializer: captures one packed vector and streams
// its elements, requantized with round-half-up and saturation.
module hidden_vector_serializer #(
    parameter int HIDDEN_SIZE = 20,
    parameter int BW_IN       = 32,
    parameter int FRAC_IN     = 15,
    parameter int BW_OUT      = 16,
    parameter int FRAC_OUT    = 12,
    parameter int IDX_W       = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [HIDDEN_SIZE*BW_IN-1:0] vec_bus,
    input  logic                         vec_valid,
    output logic                         vec_ready,
    output logic [BW_OUT-1:0]            elem_data,
    output logic [IDX_W-1:0]             elem_index,
    output logic                         elem_last,
    output logic                         elem_valid,
    input  logic                         elem_ready,
    output logic                         sat_flag
);

    localparam int SH = FRAC_IN - FRAC_OUT;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIDDEN_SIZE - 1);

    // Saturation bounds expressed in the widened (BW_IN+1) domain
    localparam logic signed [BW_IN:0] OUT_MAX =
        {{(BW_IN - BW_OUT + 2){1'b0}}, {(BW_OUT - 1){1'b1}}};
    localparam logic signed [BW_IN:0] OUT_MIN =
        {{(BW_IN - BW_OUT + 2){1'b1}}, {(BW_OUT - 1){1'b0}}};

    localparam logic [BW_OUT-1:0] SAT_MAX = {1'b0, {(BW_OUT - 1){1'b1}}};
    localparam logic [BW_OUT-1:0] SAT_MIN = {1'b1, {(BW_OUT - 1){1'b0}}};

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_q, idx_d;

    logic [BW_IN-1:0] cap_q [HIDDEN_SIZE];
    logic [BW_IN-1:0] cap_d [HIDDEN_SIZE];

    logic capture;

    logic [BW_IN-1:0]        elem_sel;
    logic signed [BW_IN:0]   x_ext;
    logic signed [BW_IN:0]   t_w;

    // FSM state and element index register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Capture register: the only place vec_bus is ever sampled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                cap_q[i] <= '0;
            end
        end else begin
            cap_q <= cap_d;
        end
    end

    // Next-state logic: accept a vector in IDLE, walk the index in STREAM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (vec_valid) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (elem_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Unpack the MSB-first bus into per-element capture slots
    always_comb begin
        cap_d = cap_q;
        if (capture) begin
            for (int i = 0; i < HIDDEN_SIZE; i++) begin
                cap_d[i] = vec_bus[(HIDDEN_SIZE-1-i)*BW_IN +: BW_IN];
            end
        end
    end

    assign elem_sel = cap_q[idx_q];
    assign x_ext    = {elem_sel[BW_IN-1], elem_sel};

    // Round-half-up shift; one extra bit keeps the rounding add exact
    generate
        if (SH > 0) begin : g_round
            localparam logic signed [BW_IN:0] HALF =
                (BW_IN + 1)'(1) << (SH - 1);
            logic signed [BW_IN:0] rnd_sum;
            assign rnd_sum = x_ext + HALF;
            assign t_w     = rnd_sum >>> SH;
        end else begin : g_pass
            assign t_w = x_ext;
        end
    endgenerate

    // Output decode: handshake flags and saturated element per state
    always_comb begin
        vec_ready  = 1'b0;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
        elem_data  = '0;
        sat_flag   = 1'b0;
        elem_index = idx_q;
        unique case (state_q)
            S_IDLE: begin
                vec_ready = 1'b1;
            end
            S_STREAM: begin
                elem_valid = 1'b1;
                elem_last  = (idx_q == LAST_IDX);
                if (t_w > OUT_MAX) begin
                    elem_data = SAT_MAX;
                    sat_flag  = 1'b1;
                end else if (t_w < OUT_MIN) begin
                    elem_data = SAT_MIN;
                    sat_flag  = 1'b1;
                end else begin
                    elem_data = t_w[BW_OUT-1:0];
                end
            end
            default: begin
                vec_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hidden_vector_serializer.sv
// Self-checking bench for hidden_vector_serializer.
// Arithmetic reference model predicts every handshake beat.
module tb_hidden_vector_serializer;

    localparam int HS  = 20;
    localparam int BWI = 32;
    localparam int FI  = 15;
    localparam int BWO = 16;
    localparam int FO  = 12;
    localparam int IW  = 5;

    localparam int     SH    = FI - FO;
    localparam longint SCALE = longint'(1) << SH;
    localparam longint OMAX  = (longint'(1) << (BWO - 1)) - 1;
    localparam longint OMIN  = -(longint'(1) << (BWO - 1));

    localparam int PH_NONE = 0;
    localparam int PH_UNI  = 1;
    localparam int PH_ORD  = 2;
    localparam int PH_RAMP = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [HS*BWI-1:0]     vec_bus = '0;
    logic                  vec_valid = 1'b0;
    logic                  vec_ready;
    logic signed [BWO-1:0] elem_data;
    logic [IW-1:0]         elem_index;
    logic                  elem_last;
    logic                  elem_valid;
    logic                  elem_ready = 1'b0;
    logic                  sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    bit     chk_en  = 1'b0;
    bit     m_busy  = 1'b0;
    bit     m_fresh = 1'b1;
    int     m_idx   = 0;
    int     m_hs    = 0;
    int     m_caps  = 0;
    longint m_data [HS];
    bit     m_sat  [HS];

    int     phase   = PH_NONE;
    int     rmode   = 0;
    int     pat_cnt = 0;
    longint va [HS];
    longint ord_exp [5] = '{1, 0, 2, 32767, -32768};

    always #5 clk = ~clk;

    hidden_vector_serializer #(
        .HIDDEN_SIZE(HS),
        .BW_IN      (BWI),
        .FRAC_IN    (FI),
        .BW_OUT     (BWO),
        .FRAC_OUT   (FO),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_bus   (vec_bus),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .elem_data (elem_data),
        .elem_index(elem_index),
        .elem_last (elem_last),
        .elem_valid(elem_valid),
        .elem_ready(elem_ready),
        .sat_flag  (sat_flag)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Real-valued rounding: floor(x/2^SH + 1/2) via integer division
    function automatic longint rq_raw(input longint x);
        longint s;
        s = x + SCALE / 2;
        if (s >= 0) return s / SCALE;
        return -((-s + SCALE - 1) / SCALE);
    endfunction

    function automatic logic [HS*BWI-1:0] pack_vec();
        logic [HS*BWI-1:0] b;
        logic [63:0] w;
        b = '0;
        for (int i = 0; i < HS; i++) begin
            w = va[i];
            b[(HS-1-i)*BWI +: BWI] = w[BWI-1:0];
        end
        return b;
    endfunction

    task automatic rand_vec();
        for (int i = 0; i < HS; i++) begin
            if ($urandom_range(0, 3) == 0)
                va[i] = longint'($signed($urandom()));
            else
                va[i] = longint'($urandom_range(0, 600000)) - 300000;
        end
    endtask

    // Monitor and reference model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("vec_ready", vec_ready, !m_busy);
            chk("elem_valid", elem_valid, m_busy);
            if (m_busy) begin
                chk("elem_index", elem_index, m_idx);
                chk("elem_data", elem_data, m_data[m_idx]);
                chk("sat_flag", sat_flag, m_sat[m_idx]);
                chk("elem_last", elem_last, m_idx == HS - 1);
                if (elem_ready) begin
                    if (phase == PH_UNI)
                        chk("uni_data", elem_data, 2048);
                    if (phase == PH_ORD)
                        chk("ord_data", elem_data,
                            (m_idx < 5) ? ord_exp[m_idx] : 0);
                    if (phase == PH_RAMP)
                        chk("ramp_data", elem_data, m_idx);
                end
            end else begin
                chk("idle_index", elem_index, 0);
                chk("idle_last", elem_last, 0);
                if (m_fresh) chk("idle_data", elem_data, 0);
            end
        end
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_idx   = 0;
            m_fresh = 1'b1;
        end else if (!m_busy) begin
            if (vec_valid) begin
                for (int i = 0; i < HS; i++) begin
                    longint t;
                    t = rq_raw(longint'($signed(vec_bus[(HS-1-i)*BWI +: BWI])));
                    m_sat[i]  = (t > OMAX) || (t < OMIN);
                    m_data[i] = (t > OMAX) ? OMAX : ((t < OMIN) ? OMIN : t);
                end
                m_busy  = 1'b1;
                m_idx   = 0;
                m_fresh = 1'b0;
                m_caps++;
            end
        end else if (elem_ready) begin
            m_hs++;
            if (m_idx == HS - 1) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end
    end

    // Consumer ready: steady, 1-0-0-1 pattern, or random
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: elem_ready = 1'b1;
            1: begin
                elem_ready = (pat_cnt % 4 == 0) || (pat_cnt % 4 == 3);
                pat_cnt++;
            end
            2: elem_ready = 1'($urandom_range(0, 1));
            default: elem_ready = 1'b0;
        endcase
    end

    task automatic send_vec(input logic [HS*BWI-1:0] v);
        int c0;
        int n;
        c0 = m_caps;
        n  = 0;
        @(posedge clk);
        #1;
        vec_bus   = v;
        vec_valid = 1'b1;
        while (m_caps == c0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        vec_valid = 1'b0;
        chk("capture_count", m_caps, c0 + 1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (m_busy && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("idle_reached", m_busy, 0);
    endtask

    initial begin
        int hs0;
        int c0;
        int n;

        rmode = 0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        phase = PH_UNI;
        for (int i = 0; i < HS; i++) va[i] = 16384;
        hs0 = m_hs;
        send_vec(pack_vec());
        wait_idle(100);
        chk("uni_beats", m_hs - hs0, HS);

        phase = PH_ORD;
        for (int i = 0; i < HS; i++) va[i] = 0;
        va[0] = 4;
        va[1] = -4;
        va[2] = 12;
        va[3] = 64'sh7FFFFFFF;
        va[4] = -64'sh80000000;
        send_vec(pack_vec());
        wait_idle(100);

        phase = PH_RAMP;
        pat_cnt = 0;
        rmode = 1;
        for (int i = 0; i < HS; i++) va[i] = i * 8;
        hs0 = m_hs;
        send_vec(pack_vec());
        wait_idle(200);
        chk("ramp_beats", m_hs - hs0, HS);

        phase = PH_NONE;
        rmode = 2;
        rand_vec();
        send_vec(pack_vec());
        rand_vec();
        c0 = m_caps;
        vec_bus   = pack_vec();
        vec_valid = 1'b1;
        n = 0;
        while (m_caps == c0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        vec_valid = 1'b0;
        chk("held_capture", m_caps, c0 + 1);
        wait_idle(400);

        rmode = 0;
        rand_vec();
        hs0 = m_hs;
        send_vec(pack_vec());
        n = 0;
        while (m_hs < hs0 + 7 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("pre_reset_beats", m_hs - hs0, 7);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_vec_ready", vec_ready, 1);
        chk("rst_elem_valid", elem_valid, 0);
        chk("rst_elem_index", elem_index, 0);
        rand_vec();
        hs0 = m_hs;
        send_vec(pack_vec());
        wait_idle(100);
        chk("post_reset_beats", m_hs - hs0, HS);

        rmode = 2;
        repeat (4) begin
            rand_vec();
            send_vec(pack_vec());
            wait_idle(400);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

endmodule
